// File: rtl/lib_axis_wrr_arbiter.sv
// Packet-granular weighted round-robin grant generator for an AXI-S mux.
// Holds a grant until the granted channel's tlast beat, then continues or rotates.
module lib_axis_wrr_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 4,
  parameter int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*WEIGHT_W-1:0]   weight,
  input  logic                         xfer,
  input  logic                         xfer_last,
  output logic                         gnt_valid,
  output logic [SEL_W-1:0]             gnt_idx,
  output logic [NUM_CH-1:0]            gnt_1hot,
  output logic                         turn_end
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    ptr, ptr_nxt;
  logic [WEIGHT_W-1:0] credit, credit_nxt;
  logic [SEL_W-1:0]    winner;
  logic [WEIGHT_W-1:0] win_wt, win_credit;
  logic                any_req, cont, te_nxt;

  // Search ptr+1 .. ptr+NUM_CH; scanning downward lets the nearest requester win.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_CH;
      if (req[idx]) begin
        winner  = SEL_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    win_wt     = weight[int'(winner)*WEIGHT_W +: WEIGHT_W];
    win_credit = (win_wt == '0) ? WEIGHT_W'(1) : win_wt;
    cont       = (credit > WEIGHT_W'(1)) && req[ptr];
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    te_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (cont) begin
          credit_nxt = credit - WEIGHT_W'(1);
          state_nxt  = BUSY;
        end else if (any_req) begin
          ptr_nxt    = winner;
          credit_nxt = win_credit;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (xfer && xfer_last) begin
          if (cont) begin
            credit_nxt = credit - WEIGHT_W'(1);
          end else if (any_req) begin
            // Re-selecting the sole requester is not a turn change.
            ptr_nxt    = winner;
            credit_nxt = win_credit;
            te_nxt     = (winner != ptr);
          end else begin
            state_nxt  = IDLE;
            te_nxt     = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= SEL_W'(NUM_CH - 1);
      credit <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      credit <= credit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      gnt_1hot  <= '0;
      turn_end  <= 1'b0;
    end else begin
      gnt_valid <= (state_nxt == BUSY);
      if (state_nxt == BUSY) gnt_idx <= ptr_nxt;
      gnt_1hot  <= (state_nxt == BUSY) ? (NUM_CH'(1) << ptr_nxt) : '0;
      turn_end  <= te_nxt;
    end
  end

endmodule

// File: tb/tb_lib_axis_wrr_arbiter.sv
// Directed bench for lib_axis_wrr_arbiter: vector table plus multi-cycle sequences.
module tb_lib_axis_wrr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        xfer, xfer_last;
  logic        gnt_valid;
  logic [1:0]  gnt_idx;
  logic [3:0]  gnt_1hot;
  logic        turn_end;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lib_axis_wrr_arbiter #(.NUM_CH(4), .WEIGHT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .weight(weight),
    .xfer(xfer), .xfer_last(xfer_last),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_1hot(gnt_1hot), .turn_end(turn_end)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] weight;
    logic        xfer;
    logic        last;
    logic        ev;
    logic [1:0]  eidx;
    logic        ete;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [15:0] w, logic x, logic l,
                              logic ev, logic [1:0] ei, logic ete);
    vec_t v;
    v.rst_n = r; v.req = rq; v.weight = w; v.xfer = x; v.last = l;
    v.ev = ev; v.eidx = ei; v.ete = ete;
    return v;
  endfunction

  task automatic drv(logic r, logic [3:0] rq, logic [15:0] w, logic x, logic l);
    rst_n = r; req = rq; weight = w; xfer = x; xfer_last = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic ev, logic [1:0] ei, logic ete);
    logic [3:0] eh;
    eh = ev ? (4'b0001 << ei) : 4'b0000;
    n_cmp++;
    if (gnt_valid !== ev || (ev && gnt_idx !== ei) || gnt_1hot !== eh || turn_end !== ete) begin
      n_bad++;
      $display("FAIL %s: got v=%0b idx=%0d hot=%b te=%0b, want v=%0b idx=%0d hot=%b te=%0b",
               nm, gnt_valid, gnt_idx, gnt_1hot, turn_end, ev, ei, eh, ete);
    end
  endtask

  task automatic chk_val(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  initial begin
    int ord[15] = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0, 1, 2, 3, 3, 0};
    int te_cnt;

    drv(1'b0, 4'h0, 16'h1111, 1'b0, 1'b0);

    // Reset and idle
    vecs.push_back(mk(0, 4'h0, 16'h1111, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, 4'h0, 16'h1111, 0, 0, 0, 0, 0));
    // All weights 1, single-beat packets: 0,1,2,3,0,...
    vecs.push_back(mk(1, 4'hF, 16'h1111, 0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 4'hF, 16'h1111, 1, 1, 1, 2'((i + 1) % 4), 1));
    vecs.push_back(mk(1, 4'h0, 16'h1111, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 4'h0, 16'h1111, 0, 0, 0, 0, 0));
    // Only ch2: sole-requester reselect gives no turn_end; req drop on last packet releases
    vecs.push_back(mk(1, 4'h4, 16'h1111, 0, 0, 1, 2, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 4'h4, 16'h1111, 1, 1, 1, 2, 0));
    vecs.push_back(mk(1, 4'h0, 16'h1111, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 4'h0, 16'h1111, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 16'h1111, 1, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      drv(vecs[i].rst_n, vecs[i].req, vecs[i].weight, vecs[i].xfer, vecs[i].last);
      tick();
      chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eidx, vecs[i].ete);
      if (i == 0) chk_val("rst_idx", int'(gnt_idx), 0);
    end

    // Weights ch0=3 ch1=1 ch2=0 ch3=2, all requesting, 2-beat packets
    drv(0, 4'hF, 16'h2013, 0, 0); tick(); chk("t3_rst", 0, 0, 0);
    drv(1, 4'hF, 16'h2013, 0, 0); tick(); chk("t3_first", 1, 0, 0);
    te_cnt = 0;
    for (int p = 0; p < 14; p++) begin
      drv(1, 4'hF, 16'h2013, 1, 0); tick();
      chk($sformatf("t3_p%0d_b1", p), 1, 2'(ord[p]), 0);
      te_cnt += int'(turn_end);
      drv(1, 4'hF, 16'h2013, 1, 1); tick();
      chk($sformatf("t3_p%0d_b2", p), 1, 2'(ord[p+1]), ord[p+1] != ord[p]);
      te_cnt += int'(turn_end);
    end
    chk_val("t3_turn_end_count", te_cnt, 8);

    // Mid-packet weight change on ch1 and new req on ch3
    drv(0, 4'h2, 16'h1111, 0, 0); tick(); chk("t5_rst", 0, 0, 0);
    drv(1, 4'h2, 16'h1111, 0, 0); tick(); chk("t5_gnt", 1, 1, 0);
    drv(1, 4'h2, 16'h1111, 1, 0); tick(); chk("t5_b1", 1, 1, 0);
    drv(1, 4'hA, 16'h1151, 1, 0); tick(); chk("t5_b2", 1, 1, 0);
    drv(1, 4'hA, 16'h1151, 1, 0); tick(); chk("t5_b3", 1, 1, 0);
    drv(1, 4'hA, 16'h1151, 1, 1); tick(); chk("t5_b4", 1, 3, 1);
    drv(1, 4'hA, 16'h1151, 1, 1); tick(); chk("t5_ch3", 1, 1, 1);
    drv(1, 4'hA, 16'h1151, 1, 1); tick(); chk("t5_ch1_cont", 1, 1, 0);

    // Reset during beat 2 of a ch0 packet
    drv(0, 4'h3, 16'h1111, 0, 0); tick(); chk("t6_rst", 0, 0, 0);
    drv(1, 4'h3, 16'h1111, 0, 0); tick(); chk("t6_gnt", 1, 0, 0);
    drv(1, 4'h3, 16'h1111, 1, 0); tick(); chk("t6_b1", 1, 0, 0);
    drv(0, 4'h3, 16'h1111, 1, 0); tick(); chk("t6_midrst", 0, 0, 0);
    chk_val("t6_midrst_idx", int'(gnt_idx), 0);
    drv(1, 4'h3, 16'h1111, 0, 0); tick(); chk("t6_regrant", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lib_axis_wrr_arbiter.md
Name: lib_axis_wrr_arbiter

Overview:
- Packet-granular weighted round-robin scheduler for a multi-channel PCIe SS AXI-S mux.
- Grants one input channel at a time and holds the grant until that channel's tlast beat is accepted.
- Channel i may send up to weight[i] consecutive packets before the grant rotates.
- Sits beside the mux datapath, driving its select lines; it does not touch tdata.

Parameters:
- NUM_CH, 4, number of requesting channels (≥2).
- WEIGHT_W, 4, width of each per-channel weight (packets per turn).
- SEL_W, $clog2(NUM_CH), width of gnt_idx.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_CH  per-channel tvalid (packet pending / in progress).
- weight  input  NUM_CH*WEIGHT_W  per-channel quantum in packets; slice i = weight[i*WEIGHT_W +: WEIGHT_W]; value 0 is treated as 1.
- xfer  input  1  beat accepted on the granted channel (mux-side tvalid & tready).
- xfer_last  input  1  tlast of the accepted beat; qualified by xfer.
- gnt_valid  output  1  grant active.
- gnt_idx  output  SEL_W  granted channel index.
- gnt_1hot  output  NUM_CH  one-hot grant; all zero when gnt_valid=0.
- turn_end  output  1  one-cycle pulse when a channel's turn ends (credit exhausted, or no further request).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: gnt_valid=0, gnt_idx=0, gnt_1hot=0, turn_end=0.
  - Internal: ptr=NUM_CH-1 (channel 0 wins first), credit=0, state=IDLE.
- Reset mid-packet drops the grant immediately; the packet is not tracked further.
- States:
  - IDLE: no grant.
  - BUSY: grant held for a packet in progress.
- Decision point: each cycle where state=IDLE, or where (state=BUSY & xfer & xfer_last).
- Decision, evaluated combinationally from the current req, credit and ptr:
  - Continue: if credit>1 and req[ptr]=1, keep ptr and decrement credit.
  - Rotate: otherwise search ptr+1, ptr+2, … (mod NUM_CH) for the first set req bit, ending with ptr itself. Load ptr=winner and credit=max(weight[winner],1).
  - Weight is sampled only on rotate; changing weight mid-turn does not affect the current credit.
- Outputs are registered. The grant reflects the decision one cycle after the decision point.
- Back-to-back packets: a decision on the last-beat cycle gives the next grant on the following cycle with no bubble.
- Idle decision:
  - No req set: stay IDLE, gnt_valid stays 0, credit/ptr unchanged.
  - Otherwise go to BUSY with gnt_valid=1.
- Last beat with no req set: next cycle gnt_valid=0, state=IDLE.
- BUSY:
  - gnt_idx and gnt_1hot are stable until xfer & xfer_last.
  - xfer without xfer_last only counts a beat; the grant is unchanged.
  - Deassertion of req on the granted channel does not release the grant (AXI-S forbids tvalid drop mid-packet).
- xfer while gnt_valid=0 is ignored.
- Single-beat packets (xfer & xfer_last on the first beat) are legal; the decision happens that same cycle.
- turn_end:
  - Asserted in the cycle after a decision that rotates away from, or releases, a channel that held the grant.
  - Not asserted when a rotate re-selects the same channel because it is the only requester.
  - Not asserted on a continue decision.
- Credit is WEIGHT_W bits and never underflows: credit=1 at a decision forces a rotate.
- Fairness: with all channels requesting, channel i receives exactly max(weight[i],1) packets per round, in index order starting after the last holder.

Test Plan:
- Reset, req=4'b0000 for 10 cycles → gnt_valid=0, gnt_1hot=0, turn_end=0 throughout.
- weights all 1, req=4'b1111, every packet 1 beat with xfer=1 each granted cycle → gnt_idx sequence 0,1,2,3,0,1…; no idle cycles between grants.
- weights {ch0=3,ch1=1,ch2=0,ch3=2}, all requesting, 2-beat packets → per round ch0×3, ch1×1, ch2×1, ch3×2; turn_end pulses exactly 4 times per round; grant never changes on a non-last beat.
- Only ch2 requesting, weight[2]=1, 5 single-beat packets → gnt_idx=2 for all, continuous gnt_valid, no turn_end; drop req after the last packet → gnt_valid=0 the next cycle.
- ch1 granted mid 4-beat packet; change weight[1] from 1 to 5 and raise req[3] → ch1 completes its packet, then ch3 is granted.
- Assert rst_n=0 during beat 2 of a ch0 packet with ch0/ch1 requesting → next cycle gnt_valid=0; after release, ch0 is granted first.
